// File: rtl/seg_scan_reader.sv
// seg_scan_reader
//   Loopback monitor for a multiplexed 4-digit active-low 7-segment bus.
//   Samples the anode/segment pins once per cycle. Once a single-digit pattern
//   has been stable long enough, it decodes the segments back to the 4-bit
//   value and stores it for that digit.
//   Optional feature macro: SEG_DP_CAPTURE_EN. When it is defined, the decimal
//   point is captured on dp_out and counts towards pattern stability. When it
//   is not defined, there is no dp_out port and seg[7] is ignored.

module seg_scan_reader #(
    parameter int STABLE_CYCLES = 4,  // identical samples required before capture (>=2)
    parameter int CNT_W         = 8   // stability counter width, must hold STABLE_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dig_valid,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic        code_err,
    output logic        multi_err
`ifdef SEG_DP_CAPTURE_EN
   ,output logic [3:0]  dp_out
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } state_t;

    // Bits of the segment bus that take part in the "same pattern" comparison.
`ifdef SEG_DP_CAPTURE_EN
    localparam logic [7:0] SEG_MASK = 8'hFF;
`else
    localparam logic [7:0] SEG_MASK = 8'h7F;
`endif

    localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // Returns {code_err, value}. Unknown patterns decode to F and flag an error.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0010000: r = {1'b0, 4'h9};
            7'b0000110: r = {1'b0, 4'hE};
            7'b1111111: r = {1'b0, 4'hB};
            default:    r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    // Sample registers: the current sample and the one before it.
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_prev_q, an_prev_d;
    logic [7:0]       seg_prev_q, seg_prev_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       dig_valid_q, dig_valid_d;
    logic             upd_q, upd_d;
    logic [1:0]       upd_idx_q, upd_idx_d;
    logic             code_err_q, code_err_d;
    logic             multi_err_q, multi_err_d;
`ifdef SEG_DP_CAPTURE_EN
    logic [3:0]       dp_q, dp_d;
`endif

    // Derived from the current sample.
    logic [2:0]       n_low;
    logic [1:0]       sel_idx;
    logic             same_pattern;
    logic [4:0]       dec;

    // Classify the current sample: how many anodes are low, which one, and
    // whether it matches the previous sample.
    always_comb begin
        n_low        = 3'($countones(~an_q));
        sel_idx      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an_q[i]) sel_idx = 2'(i);
        end
        same_pattern = ({an_q, seg_q & SEG_MASK} == {an_prev_q, seg_prev_q & SEG_MASK});
        dec          = decode_seg(seg_q[6:0]);
    end

    // Next-state logic for the sampler, the stability FSM and the capture outputs.
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        an_d        = an;
        seg_d       = seg;
        an_prev_d   = an_q;
        seg_prev_d  = seg_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        digits_d    = digits_q;
        dig_valid_d = dig_valid_q;
        upd_d       = 1'b0;
        upd_idx_d   = upd_idx_q;
        code_err_d  = 1'b0;
        multi_err_d = 1'b0;
`ifdef SEG_DP_CAPTURE_EN
        dp_d        = dp_q;
`endif

        if (n_low > 3'd1) begin
            // Several anodes low at once: not a valid scan sample.
            multi_err_d = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (n_low == 3'd1) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_ONE;
                    end
                end

                SETTLE: begin
                    if (n_low == 3'd0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!same_pattern) begin
                        cnt_d = CNT_ONE;
                    end else if (cnt_q >= CNT_STABLE) begin
                        // Stable long enough: capture this digit.
                        for (int i = 0; i < 4; i++) begin
                            if (sel_idx == 2'(i)) begin
                                digits_d[4*i +: 4] = dec[3:0];
                                dig_valid_d[i]     = 1'b1;
`ifdef SEG_DP_CAPTURE_EN
                                dp_d[i]            = ~seg_q[7];
`endif
                            end
                        end
                        upd_d      = 1'b1;
                        upd_idx_d  = sel_idx;
                        code_err_d = dec[4];
                        state_d    = CAPTURED;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                CAPTURED: begin
                    // Hold while the pattern is unchanged; any change re-arms.
                    if (n_low == 3'd0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (!same_pattern) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset puts the sampler into the "nothing
    // driven" pattern so the first real sample always starts a fresh run.
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // sees the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q        <= 4'hF;
            seg_q       <= 8'hFF;
            an_prev_q   <= 4'hF;
            seg_prev_q  <= 8'hFF;
            state_q     <= IDLE;
            cnt_q       <= '0;
            digits_q    <= 16'h0;
            dig_valid_q <= 4'h0;
            upd_q       <= 1'b0;
            upd_idx_q   <= 2'd0;
            code_err_q  <= 1'b0;
            multi_err_q <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
            dp_q        <= 4'h0;
`endif
        end else begin
            an_q        <= an_d;
            seg_q       <= seg_d;
            an_prev_q   <= an_prev_d;
            seg_prev_q  <= seg_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            dig_valid_q <= dig_valid_d;
            upd_q       <= upd_d;
            upd_idx_q   <= upd_idx_d;
            code_err_q  <= code_err_d;
            multi_err_q <= multi_err_d;
`ifdef SEG_DP_CAPTURE_EN
            dp_q        <= dp_d;
`endif
        end
    end

    assign digits    = digits_q;
    assign dig_valid = dig_valid_q;
    assign upd       = upd_q;
    assign upd_idx   = upd_idx_q;
    assign code_err  = code_err_q;
    assign multi_err = multi_err_q;
`ifdef SEG_DP_CAPTURE_EN
    assign dp_out    = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader
//   Scoreboard bench: a pattern-run reference model predicts every upd and
//   multi_err pulse, and when each should appear. A separate monitor pops the
//   predictions and compares them whenever the DUT pulses.
//   Honours SEG_DP_CAPTURE_EN the same way the design does.

module tb_seg_scan_reader;

    localparam int STABLE = 4;

`ifdef SEG_DP_CAPTURE_EN
    localparam logic [7:0] MASK = 8'hFF;
`else
    localparam logic [7:0] MASK = 8'h7F;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        code_err;
    logic        multi_err;
`ifdef SEG_DP_CAPTURE_EN
    logic [3:0]  dp_out;
`endif

    always #5 clk = ~clk;

    seg_scan_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .an        (an),
        .seg       (seg),
        .digits    (digits),
        .dig_valid (dig_valid),
        .upd       (upd),
        .upd_idx   (upd_idx),
        .code_err  (code_err),
        .multi_err (multi_err)
`ifdef SEG_DP_CAPTURE_EN
       ,.dp_out    (dp_out)
`endif
    );

    typedef struct {
        int          cyc;
        logic        is_multi;
        logic [1:0]  idx;
        logic        cerr;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  dp;
    } exp_t;

    exp_t q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int upd_seen    = 0;
    int multi_seen  = 0;

    // Reference model state: the last sample pattern and how many times in a
    // row it has been seen as a single-digit pattern.
    logic [11:0] m_prev;
    int          m_run;
    logic [15:0] m_digits;
    logic [3:0]  m_valid;
    logic [3:0]  m_dp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b0, 4'h0};
            7'b1111001: return {1'b0, 4'h1};
            7'b0100100: return {1'b0, 4'h2};
            7'b0110000: return {1'b0, 4'h3};
            7'b0011001: return {1'b0, 4'h4};
            7'b0010010: return {1'b0, 4'h5};
            7'b0000010: return {1'b0, 4'h6};
            7'b1111000: return {1'b0, 4'h7};
            7'b0000000: return {1'b0, 4'h8};
            7'b0010000: return {1'b0, 4'h9};
            7'b0000110: return {1'b0, 4'hE};
            7'b1111111: return {1'b0, 4'hB};
            default:    return {1'b1, 4'hF};
        endcase
    endfunction

    task automatic model_reset();
        m_prev   = 12'hFFF;
        m_run    = 0;
        m_digits = 16'h0;
        m_valid  = 4'h0;
        m_dp     = 4'h0;
    endtask

    // A value driven just after edge c is sampled on edge c+1. A capture needs
    // STABLE+1 identical single-digit samples in a row. Its pulse, like a
    // multi-anode pulse, shows up on edge c+2.
    task automatic model_step(input logic [3:0] a, input logic [7:0] s, input int c);
        int          nlow;
        int          pos;
        logic [11:0] key;
        logic [4:0]  d;
        exp_t        e;
        nlow = 0;
        pos  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                nlow++;
                pos = i;
            end
        end
        key = {a, s & MASK};
        if (nlow == 1) begin
            if (m_run > 0 && key == m_prev) m_run++;
            else m_run = 1;
            if (m_run == STABLE + 1) begin
                d = ref_decode(s[6:0]);
                m_digits[pos*4 +: 4] = d[3:0];
                m_valid[pos]         = 1'b1;
                m_dp[pos]            = ~s[7];
                e.cyc      = c + 2;
                e.is_multi = 1'b0;
                e.idx      = 2'(pos);
                e.cerr     = d[4];
                e.digits   = m_digits;
                e.valid    = m_valid;
                e.dp       = m_dp;
                q.push_back(e);
            end
        end else begin
            m_run = 0;
            if (nlow > 1) begin
                e.cyc      = c + 2;
                e.is_multi = 1'b1;
                e.idx      = 2'd0;
                e.cerr     = 1'b0;
                e.digits   = m_digits;
                e.valid    = m_valid;
                e.dp       = m_dp;
                q.push_back(e);
            end
        end
        m_prev = key;
    endtask

    // Called just after a rising edge; drives the value for n cycles.
    task automatic step(input logic [3:0] a, input logic [7:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            an  = a;
            seg = s;
            model_step(a, s, cyc);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every DUT pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (code_err) check("code_err_without_upd", 32'(upd), 32'd1);
            if (upd || multi_err) begin
                if (upd) upd_seen++;
                if (multi_err) multi_seen++;
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: upd=%0b multi_err=%0b with nothing predicted (cycle %0d)",
                             upd, multi_err, cyc);
                end else begin
                    e = q.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    check("pulse_multi_err", 32'(multi_err), 32'(e.is_multi));
                    check("pulse_upd", 32'(upd), 32'(!e.is_multi));
                    check("digits", 32'(digits), 32'(e.digits));
                    check("dig_valid", 32'(dig_valid), 32'(e.valid));
                    if (!e.is_multi) begin
                        check("upd_idx", 32'(upd_idx), 32'(e.idx));
                        check("code_err", 32'(code_err), 32'(e.cerr));
`ifdef SEG_DP_CAPTURE_EN
                        check("dp_out", 32'(dp_out), 32'(e.dp));
`endif
                    end
                end
            end
        end
    end

    logic [7:0] codes [12] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                               8'h82, 8'hF8, 8'h80, 8'h90, 8'h86, 8'hFF};
    logic [3:0] multis [5] = '{4'hC, 4'h3, 4'h5, 4'h0, 4'hA};

    initial begin
        int        base_upd;
        int        base_multi;
        logic [3:0] ra;
        logic [7:0] rs;
        int         r;

        rst = 1'b1;
        an  = 4'hF;
        seg = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_dig_valid", 32'(dig_valid), 32'h0);
        check("reset_upd", 32'(upd), 32'h0);
        check("reset_upd_idx", 32'(upd_idx), 32'h0);
        check("reset_code_err", 32'(code_err), 32'h0);
        check("reset_multi_err", 32'(multi_err), 32'h0);
        rst = 1'b0;

        // Single digit 0 held 6 cycles: exactly one capture.
        base_upd = upd_seen;
        step(4'hE, 8'hC0, 6);
        step(4'hF, 8'hFF, 4);
        check("s1_upd_count", 32'(upd_seen - base_upd), 32'd1);
        check("s1_digit0", 32'(digits[3:0]), 32'h0);
        check("s1_upd_idx", 32'(upd_idx), 32'd0);
        check("s1_dig_valid", 32'(dig_valid), 32'b0001);

        // Full scan 1,2,3,9.
        base_upd = upd_seen;
        step(4'hE, 8'hF9, 8);
        step(4'hD, 8'hA4, 8);
        step(4'hB, 8'hB0, 8);
        step(4'h7, 8'h90, 8);
        step(4'hF, 8'hFF, 3);
        check("s2_upd_count", 32'(upd_seen - base_upd), 32'd4);
        check("s2_digits", 32'(digits), 32'h9321);
        check("s2_dig_valid", 32'(dig_valid), 32'hF);

        // Flicker on digit 1 never settles; then 3 is held.
        base_upd = upd_seen;
        for (int k = 0; k < 4; k++) begin
            step(4'hD, 8'hA4, 3);
            step(4'hD, 8'hB0, 3);
        end
        check("s3_no_upd_while_flicker", 32'(upd_seen - base_upd), 32'd0);
        step(4'hD, 8'hB0, 8);
        step(4'hF, 8'hFF, 3);
        check("s3_upd_count", 32'(upd_seen - base_upd), 32'd1);
        check("s3_digit1", 32'(digits[7:4]), 32'h3);

        // One multi-anode glitch in the middle of a stable digit.
        base_upd   = upd_seen;
        base_multi = multi_seen;
        step(4'hB, 8'hC0, 3);
        step(4'hC, 8'hC0, 1);
        step(4'hB, 8'hC0, 7);
        step(4'hF, 8'hFF, 3);
        check("s4_multi_count", 32'(multi_seen - base_multi), 32'd1);
        check("s4_upd_count", 32'(upd_seen - base_upd), 32'd1);
        check("s4_digit2", 32'(digits[11:8]), 32'h0);

        // E is a known code; 0xAA is not.
        step(4'h7, 8'h86, 6);
        check("s5_digit3_E", 32'(digits[15:12]), 32'hE);
        step(4'h7, 8'hAA, 6);
        step(4'hF, 8'hFF, 3);
        check("s5_digit3_F", 32'(digits[15:12]), 32'hF);

        // Reset while the stability count is at 3.
        step(4'hB, 8'hA4, 4);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_digits", 32'(digits), 32'h0);
        check("rst_mid_dig_valid", 32'(dig_valid), 32'h0);
        check("rst_mid_upd", 32'(upd), 32'h0);
        check("rst_mid_upd_idx", 32'(upd_idx), 32'h0);
        check("rst_mid_pending", 32'(q.size()), 32'd0);
        model_reset();
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Decimal point on digit 2 with value 0.
        step(4'hB, 8'h40, 6);
        step(4'hF, 8'hFF, 3);
        check("dp_digit2", 32'(digits[11:8]), 32'h0);
        check("dp_dig_valid", 32'(dig_valid), 32'b0100);
`ifdef SEG_DP_CAPTURE_EN
        check("dp_out", 32'(dp_out), 32'b0100);
`endif

        // Randomised scan traffic.
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) ra = ~(4'b0001 << (r % 4));
            else if (r == 8) ra = 4'hF;
            else ra = multis[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) rs = 8'($urandom);
            else rs = {1'($urandom), codes[$urandom_range(0, 11)][6:0]};
            step(ra, rs, int'($urandom_range(1, 9)));
        end

        step(4'hF, 8'hFF, 10);
        check("end_pending_events", 32'(q.size()), 32'd0);
        check("end_digits", 32'(digits), 32'(m_digits));
        check("end_dig_valid", 32'(dig_valid), 32'(m_valid));
`ifdef SEG_DP_CAPTURE_EN
        check("end_dp_out", 32'(dp_out), 32'(m_dp));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
